// File: rtl/cache_tag_pkg.sv
// Shared encodings for the N-way MSI cache tag store: MSI line states and init FSM states.
package cache_tag_pkg;

    typedef enum logic [1:0] {
        ST_I = 2'b00,
        ST_S = 2'b01,
        ST_M = 2'b10
    } msi_e;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } init_fsm_e;

endpackage

// File: rtl/tag_way_bank.sv
// One way of the tag store: DEPTH x DW sync-read RAM with a single write port and a read
// address latched on each accepted lookup.
module tag_way_bank #(
    parameter int AWIDTH = 3,
    parameter int DW     = 11
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              we,
    input  logic [AWIDTH-1:0] waddr,
    input  logic [DW-1:0]     wdata,
    input  logic              re,
    input  logic [AWIDTH-1:0] raddr,
    output logic [DW-1:0]     rdata
);

    localparam int DEPTH = 1 << AWIDTH;

    logic [DW-1:0]     mem [DEPTH];
    logic [AWIDTH-1:0] raddr_q;

    // NOTE: the array has no reset branch so it stays a plain RAM; the top's INIT sweep clears it.
    always_ff @(posedge clock) begin
        if (we) mem[waddr] <= wdata;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)   raddr_q <= '0;
        else if (re) raddr_q <= raddr;
    end

    // Read after the edge, so a write landing on the same edge is already visible (write-first).
    assign rdata = mem[raddr_q];

endmodule

// File: rtl/cache_tag_ram_nway.sv
// N-way set-associative MSI tag/state store with self-clearing init, sync-read compare and RR victims.
// Optional build macro: TAG_PARITY_EN adds an even-parity bit per entry and drives rsp_perr.
module cache_tag_ram_nway
    import cache_tag_pkg::*;
#(
    parameter  int AWIDTH = 3,
    parameter  int TWIDTH = 9,
    parameter  int SWIDTH = 2,
    parameter  int WAYS   = 2,
    localparam int WWIDTH = $clog2(WAYS)
) (
    input  logic              clock,
    input  logic              reset,
    output logic              init_done,
    input  logic              lk_valid,
    input  logic [AWIDTH-1:0] lk_addr,
    input  logic [TWIDTH-1:0] lk_tag,
    output logic              rsp_valid,
    output logic              rsp_hit,
    output logic [WWIDTH-1:0] rsp_way,
    output logic [SWIDTH-1:0] rsp_state,
    output logic [WWIDTH-1:0] rsp_victim,
    output logic              rsp_perr,
    input  logic              wr_en,
    input  logic [AWIDTH-1:0] wr_addr,
    input  logic [WWIDTH-1:0] wr_way,
    input  logic [TWIDTH-1:0] wr_tag,
    input  logic [SWIDTH-1:0] wr_state
);

    localparam int DEPTH = 1 << AWIDTH;
    localparam int BW    = SWIDTH + TWIDTH;
`ifdef TAG_PARITY_EN
    localparam int DW    = BW + 1;
`else
    localparam int DW    = BW;
`endif

    init_fsm_e         state_q, state_d;
    logic [AWIDTH-1:0] cnt_q;
    logic              lk_go, wr_go;
    logic [BW-1:0]     wr_body;
    logic [DW-1:0]     wr_entry, bank_wdata;
    logic [AWIDTH-1:0] bank_waddr;
    logic [WAYS-1:0]   bank_we;
    logic [DW-1:0]     rd [WAYS];
    logic [WWIDTH-1:0] rr_q [DEPTH];

    // NOTE: flops use <= so every register samples pre-edge values; comb blocks use = with defaults first.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == INIT) cnt_q <= cnt_q + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        if (state_q == INIT && cnt_q == AWIDTH'(DEPTH - 1)) state_d = READY;
    end

    assign init_done = (state_q == READY);
    assign lk_go     = lk_valid & init_done;
    assign wr_go     = wr_en & init_done;
    assign wr_body   = {wr_state, wr_tag};
`ifdef TAG_PARITY_EN
    assign wr_entry  = {^wr_body, wr_body};
`else
    assign wr_entry  = wr_body;
`endif

    // The init sweep owns the write port; {I, tag 0} has even parity, so all-zero is a clean entry.
    always_comb begin
        bank_waddr = wr_addr;
        bank_wdata = wr_entry;
        bank_we    = '0;
        if (!init_done) begin
            bank_waddr = cnt_q;
            bank_wdata = '0;
            bank_we    = '1;
        end else if (wr_en) begin
            bank_we[wr_way] = 1'b1;
        end
    end

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        tag_way_bank #(.AWIDTH(AWIDTH), .DW(DW)) u_bank (
            .clock (clock),
            .reset (reset),
            .we    (bank_we[w]),
            .waddr (bank_waddr),
            .wdata (bank_wdata),
            .re    (lk_go),
            .raddr (lk_addr),
            .rdata (rd[w])
        );
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) rr_q[i] <= '0;
        end else if (wr_go && wr_way == rr_q[wr_addr]) begin
            rr_q[wr_addr] <= rr_q[wr_addr] + 1'b1;
        end
    end

    logic [AWIDTH-1:0] addr_q;
    logic [TWIDTH-1:0] tag_q;
    logic              rsp_valid_q;
    logic [SWIDTH-1:0] ent_state;
    logic [TWIDTH-1:0] ent_tag;
    logic              ent_ok, ent_valid;
    logic              hit_c, perr_c;
    logic [WWIDTH-1:0] way_c, victim_c;
    logic [SWIDTH-1:0] st_c;

    // Descending scan so the lowest-index hit and lowest-index free way win.
    always_comb begin
        hit_c     = 1'b0;
        perr_c    = 1'b0;
        way_c     = '0;
        st_c      = SWIDTH'(ST_I);
        victim_c  = rr_q[addr_q];
        ent_state = '0;
        ent_tag   = '0;
        ent_ok    = 1'b1;
        ent_valid = 1'b0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            ent_state = rd[w][BW-1:TWIDTH];
            ent_tag   = rd[w][TWIDTH-1:0];
`ifdef TAG_PARITY_EN
            ent_ok    = ~^rd[w];
`else
            ent_ok    = 1'b1;
`endif
            perr_c    = perr_c | ~ent_ok;
            ent_valid = ent_ok && (ent_state != SWIDTH'(ST_I));
            if (ent_valid && ent_tag == tag_q) begin
                hit_c = 1'b1;
                way_c = WWIDTH'(w);
                st_c  = ent_state;
            end
            if (!ent_valid) victim_c = WWIDTH'(w);
        end
    end

    logic              hold_hit, hold_perr;
    logic [WWIDTH-1:0] hold_way, hold_victim;
    logic [SWIDTH-1:0] hold_state;

    // Hold registers keep the last result stable while idle, even if the set is rewritten.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rsp_valid_q <= 1'b0;
            addr_q      <= '0;
            tag_q       <= '0;
            hold_hit    <= 1'b0;
            hold_way    <= '0;
            hold_state  <= SWIDTH'(ST_I);
            hold_victim <= '0;
            hold_perr   <= 1'b0;
        end else begin
            rsp_valid_q <= lk_go;
            if (lk_go) begin
                addr_q <= lk_addr;
                tag_q  <= lk_tag;
            end
            if (rsp_valid_q) begin
                hold_hit    <= hit_c;
                hold_way    <= way_c;
                hold_state  <= st_c;
                hold_victim <= victim_c;
                hold_perr   <= perr_c;
            end
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_hit    = rsp_valid_q ? hit_c    : hold_hit;
    assign rsp_way    = rsp_valid_q ? way_c    : hold_way;
    assign rsp_state  = rsp_valid_q ? st_c     : hold_state;
    assign rsp_victim = rsp_valid_q ? victim_c : hold_victim;
    assign rsp_perr   = rsp_valid_q ? perr_c   : hold_perr;

endmodule

// File: tb/tb_cache_tag_ram_nway.sv
// Scoreboard bench for cache_tag_ram_nway at default parameters (8 sets, 2 ways, 9-bit tags).
// Lookups push hand-computed expectations; a negedge monitor pops and compares on rsp_valid.
module tb_cache_tag_ram_nway;
    import cache_tag_pkg::*;

    typedef struct {
        logic       hit;
        logic [0:0] way;
        logic [1:0] state;
        logic [0:0] victim;
        logic       perr;
        string      name;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       init_done;
    logic       lk_valid = 1'b0;
    logic [2:0] lk_addr  = '0;
    logic [8:0] lk_tag   = '0;
    logic       rsp_valid, rsp_hit, rsp_perr;
    logic [0:0] rsp_way, rsp_victim;
    logic [1:0] rsp_state;
    logic       wr_en    = 1'b0;
    logic [2:0] wr_addr  = '0;
    logic [0:0] wr_way   = '0;
    logic [8:0] wr_tag   = '0;
    logic [1:0] wr_state = '0;

    int   checks   = 0;
    int   failures = 0;
    exp_t exp_q[$];

    cache_tag_ram_nway dut (
        .clock      (clk),
        .reset      (rst),
        .init_done  (init_done),
        .lk_valid   (lk_valid),
        .lk_addr    (lk_addr),
        .lk_tag     (lk_tag),
        .rsp_valid  (rsp_valid),
        .rsp_hit    (rsp_hit),
        .rsp_way    (rsp_way),
        .rsp_state  (rsp_state),
        .rsp_victim (rsp_victim),
        .rsp_perr   (rsp_perr),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_way     (wr_way),
        .wr_tag     (wr_tag),
        .wr_state   (wr_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every presented response must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rsp_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_rsp: got rsp_valid=1 expected no response");
                end else begin
                    e = exp_q.pop_front();
                    check({e.name, "_hit"}, rsp_hit, e.hit);
                    if (e.hit) check({e.name, "_way"}, rsp_way, e.way);
                    check({e.name, "_state"},  rsp_state,  e.state);
                    check({e.name, "_victim"}, rsp_victim, e.victim);
                    check({e.name, "_perr"},   rsp_perr,   e.perr);
                end
            end
        end
    end

    task automatic do_cycle();
        @(posedge clk);
        #1;
        lk_valid = 1'b0;
        wr_en    = 1'b0;
    endtask

    task automatic lookup(input logic [2:0] a, input logic [8:0] t, input logic h, input logic [0:0] w,
                          input logic [1:0] s, input logic [0:0] v, input logic p, input string name);
        exp_t e;
        lk_valid = 1'b1;
        lk_addr  = a;
        lk_tag   = t;
        e.hit = h; e.way = w; e.state = s; e.victim = v; e.perr = p; e.name = name;
        exp_q.push_back(e);
    endtask

    task automatic write(input logic [2:0] a, input logic [0:0] w, input logic [8:0] t, input logic [1:0] s);
        wr_en    = 1'b1;
        wr_addr  = a;
        wr_way   = w;
        wr_tag   = t;
        wr_state = s;
    endtask

    task automatic wait_init(input string name);
        int cyc = 0;
        while (cyc < 40) begin
            @(posedge clk);
            cyc++;
            #1;
            lk_valid = 1'b0;
            wr_en    = 1'b0;
            if (init_done === 1'b1) break;
        end
        check(name, cyc, 8);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_init_done",  init_done,  0);
        check("rst_rsp_valid",  rsp_valid,  0);
        check("rst_rsp_hit",    rsp_hit,    0);
        check("rst_rsp_way",    rsp_way,    0);
        check("rst_rsp_state",  rsp_state,  ST_I);
        check("rst_rsp_victim", rsp_victim, 0);
        check("rst_rsp_perr",   rsp_perr,   0);
        rst = 1'b0;
        wait_init("init_cycles");

        // Every set is empty after init: miss, victim way 0.
        for (int s = 0; s < 8; s++) begin
            lookup(3'(s), 9'h000, 0, 0, ST_I, 0, 0, $sformatf("empty_set%0d", s));
            do_cycle();
        end

        write(3, 1, 9'h1A5, ST_M);                    do_cycle();
        lookup(3, 9'h1A5, 1, 1, ST_M, 0, 0, "s3_hit"); do_cycle();
        lookup(3, 9'h0A5, 0, 0, ST_I, 0, 0, "s3_miss"); do_cycle();
        write(3, 1, 9'h1A5, ST_I);                    do_cycle();
        lookup(3, 9'h1A5, 0, 0, ST_I, 0, 0, "s3_inval"); do_cycle();

        // Set 5 round-robin: pointer 0 -> 1 -> 0 after fill, then 1, then wraps to 0.
        write(5, 0, 9'h011, ST_S);                    do_cycle();
        write(5, 1, 9'h022, ST_S);                    do_cycle();
        lookup(5, 9'h011, 1, 0, ST_S, 0, 0, "s5_full"); do_cycle();
        write(5, 0, 9'h033, ST_S);
        lookup(5, 9'h033, 1, 0, ST_S, 1, 0, "s5_rr1_wf"); do_cycle();
        write(5, 1, 9'h044, ST_S);                    do_cycle();
        lookup(5, 9'h044, 1, 1, ST_S, 0, 0, "s5_rr_wrap"); do_cycle();
        lookup(5, 9'h022, 0, 0, ST_I, 0, 0, "s5_old_miss"); do_cycle();

        write(2, 0, 9'h044, ST_S);
        lookup(2, 9'h044, 1, 0, ST_S, 1, 0, "s2_wr_first"); do_cycle();

        write(6, 0, 9'h100, ST_S);                    do_cycle();
        write(6, 1, 9'h100, ST_M);                    do_cycle();
        lookup(6, 9'h100, 1, 0, ST_S, 0, 0, "s6_lowest_way"); do_cycle();

        lookup(7, 9'h1FE, 0, 0, ST_I, 0, 0, "s7_miss");
        do_cycle();
        lookup(7, 9'h1FF, 0, 0, ST_I, 0, 0, "s7_before_wr");
        do_cycle();
        write(7, 1, 9'h1FF, ST_M);                    do_cycle();
        lookup(7, 9'h1FF, 1, 1, ST_M, 0, 0, "s7_max_tag"); do_cycle();

        // Idle after a hit while the set is invalidated: outputs hold the last response.
        write(7, 1, 9'h000, ST_I);                    do_cycle();
        do_cycle();
        check("hold_valid", rsp_valid, 0);
        check("hold_hit",   rsp_hit,   1);
        check("hold_way",   rsp_way,   1);
        check("hold_state", rsp_state, ST_M);
        check("hold_victim", rsp_victim, 0);

        // Reset lands between a lookup and its response.
        lookup(5, 9'h044, 1, 1, ST_S, 0, 0, "aborted");
        #2 rst = 1'b1;
        do_cycle();
        exp_q.delete();
        check("abort_rsp_valid", rsp_valid, 0);
        check("abort_init_done", init_done, 0);
        check("abort_rsp_hit",   rsp_hit,   0);
        do_cycle();
        do_cycle();
        rst = 1'b0;
        // Requests during INIT must be ignored.
        lk_valid = 1'b1; lk_addr = 3'd4; lk_tag = 9'h055;
        write(4, 0, 9'h055, ST_M);
        wait_init("reinit_cycles");

        lookup(5, 9'h044, 0, 0, ST_I, 0, 0, "reinit_s5"); do_cycle();
        lookup(6, 9'h100, 0, 0, ST_I, 0, 0, "reinit_s6"); do_cycle();
        lookup(2, 9'h044, 0, 0, ST_I, 0, 0, "reinit_s2"); do_cycle();
        lookup(4, 9'h055, 0, 0, ST_I, 0, 0, "init_wr_ignored"); do_cycle();

`ifdef TAG_PARITY_EN
        write(1, 0, 9'h0AA, ST_S);                    do_cycle();
        lookup(1, 9'h0AA, 1, 0, ST_S, 1, 0, "par_clean"); do_cycle();
        dut.g_way[0].u_bank.mem[1][0] = ~dut.g_way[0].u_bank.mem[1][0];
        do_cycle();
        lookup(1, 9'h0AA, 0, 0, ST_I, 0, 1, "par_err"); do_cycle();
`endif

        do_cycle();
        do_cycle();
        check("outstanding_rsp", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
